matrix_row_streamer: RTL and testbench

MATRIX_ROW_STREAMER -- requirements
Module: matrix_row_streamer

---
 rtl/matrix_row_streamer.sv | 125 ++++++++++++
 tb/tb_matrix_row_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_streamer.sv
// ============================================================================
// matrix_row_streamer: holds an N x N matrix written by a compute engine and
// streams it one row per accepted handshake. Rev 1.0
// ============================================================================
`default_nettype none

module matrix_row_streamer #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_row,
  input  logic [4:0]       wr_col,
  input  logic [W-1:0]     wr_data,
  input  logic             start,
  output logic [N*W-1:0]   row_data,
  output logic [4:0]       row_index,
  output logic             row_valid,
  input  logic             row_ready,
  output logic             row_last,
  output logic             busy,
  output logic             done
);

  localparam int         IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [5:0] c_N6   = 6'(N);
  localparam logic [4:0] c_LAST = 5'(N - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t         r_state;
  logic [4:0]     r_row_index;
  logic           r_row_valid;
  logic           r_row_last;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_mem [N][N];

  logic           w_wr_hit;
  logic [IW-1:0]  w_wr_r;
  logic [IW-1:0]  w_wr_c;
  logic [IW-1:0]  w_rd_r;
  logic           w_accept;

  // Out-of-range coordinates are dropped so they can never alias a real cell.
  assign w_wr_hit = wr_en && ({1'b0, wr_row} < c_N6) && ({1'b0, wr_col} < c_N6);
  assign w_wr_r   = wr_row[IW-1:0];
  assign w_wr_c   = wr_col[IW-1:0];
  assign w_rd_r   = r_row_index[IW-1:0];
  assign w_accept = r_row_valid && row_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_row_index <= 5'd0;
      r_row_valid <= 1'b0;
      r_row_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A write coincident with start lands before the first row is shown.
          if (w_wr_hit) begin
            r_mem[w_wr_r][w_wr_c] <= wr_data;
          end
          if (start) begin
            r_state     <= S_STREAM;
            r_row_index <= 5'd0;
            r_row_valid <= 1'b1;
            r_row_last  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            if (r_row_index == c_LAST) begin
              r_state     <= S_IDLE;
              r_row_index <= 5'd0;
              r_row_valid <= 1'b0;
              r_row_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_row_index <= r_row_index + 5'd1;
              r_row_last  <= ((r_row_index + 5'd1) == c_LAST);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_row_index <= 5'd0;
          r_row_valid <= 1'b0;
          r_row_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Column 0 occupies the most significant slice of the row bus.
  for (genvar c = 0; c < N; c++) begin : g_col
    assign row_data[N*W-1-W*c -: W] = r_mem[w_rd_r][c];
  end

  assign row_index = r_row_index;
  assign row_valid = r_row_valid;
  assign row_last  = r_row_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_matrix_row_streamer.sv
// ============================================================================
// tb_matrix_row_streamer: directed self-checking bench, N=4, W=32. Rev 1.0
// ============================================================================
`default_nettype none

module tb_matrix_row_streamer;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic           wr_en;
  logic [4:0]     wr_row;
  logic [4:0]     wr_col;
  logic [W-1:0]   wr_data;
  logic           start;
  logic [N*W-1:0] row_data;
  logic [4:0]     row_index;
  logic           row_valid;
  logic           row_ready;
  logic           row_last;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m [N][N];

  matrix_row_streamer #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .row_data  (row_data),
    .row_index (row_index),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_last  (row_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_row(input int r);
    return {m[r][0], m[r][1], m[r][2], m[r][3]};
  endfunction

  task automatic wr(input int r, input int c, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_row  = 5'(r);
    wr_col  = 5'(c);
    wr_data = d;
    step();
    wr_en   = 1'b0;
    if (r < N && c < N) m[r][c] = d;
  endtask

  // Streams the whole matrix with row_ready held high and checks every row.
  task automatic stream_all(input string tag);
    start     = 1'b1;
    row_ready = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < N; r++) begin
      chk({tag, "_valid"}, 128'(row_valid), 128'(1));
      chk({tag, "_busy"},  128'(busy), 128'(1));
      chk({tag, "_idx"},   128'(row_index), 128'(r));
      chk({tag, "_data"},  row_data, exp_row(r));
      chk({tag, "_last"},  128'(row_last), 128'(r == N - 1));
      step();
    end
    chk({tag, "_done"},     128'(done), 128'(1));
    chk({tag, "_endvalid"}, 128'(row_valid), 128'(0));
    chk({tag, "_endbusy"},  128'(busy), 128'(0));
    row_ready = 1'b0;
    step();
    chk({tag, "_donepulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    int ei;
    reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    start = 1'b0; row_ready = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = '0;
    step();
    step();
    chk("rst_valid", 128'(row_valid), 128'(0));
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_done",  128'(done), 128'(0));
    chk("rst_idx",   128'(row_index), 128'(0));
    chk("rst_last",  128'(row_last), 128'(0));
    chk("rst_data",  row_data, 128'(0));
    reset = 1'b0;
    step();

    // Fill the matrix with [r][c] = 0x100*r + c.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        wr(r, c, 32'h0000_0100 * r + c);
    chk("idle_row0", row_data, 128'h00000000_00000001_00000002_00000003);
    chk("idle_valid", 128'(row_valid), 128'(0));

    // Full stream, plus a hand-computed check on row 2.
    start = 1'b1; row_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("row2_const", row_data, 128'h00000200_00000201_00000202_00000203);
    step();
    chk("row3_last", 128'(row_last), 128'(1));
    step();
    chk("s1_done", 128'(done), 128'(1));
    row_ready = 1'b0;
    step();
    chk("s1_done_off", 128'(done), 128'(0));

    stream_all("full");

    // Ready pattern 1,0,0,1,... ; rows must stall stably and advance in order.
    start = 1'b1; row_ready = 1'b0;
    step();
    start = 1'b0;
    ei = 0;
    for (int k = 0; k < 20 && ei < N; k++) begin
      chk("stall_valid", 128'(row_valid), 128'(1));
      chk("stall_idx",   128'(row_index), 128'(ei));
      chk("stall_data",  row_data, exp_row(ei));
      chk("stall_last",  128'(row_last), 128'(ei == N - 1));
      row_ready = ((k % 3) == 0);
      step();
      if (row_ready) ei++;
    end
    chk("stall_done", 128'(done), 128'(1));
    row_ready = 1'b0;
    step();

    // Out-of-range writes must not alter storage.
    wr(4, 0, 32'hDEAD_BEEF);
    wr(0, 4, 32'hDEAD_BEEF);
    wr(31, 31, 32'hDEAD_BEEF);
    stream_all("oob");

    // Writes and start during STREAM are ignored.
    start = 1'b1; row_ready = 1'b0;
    step();
    start = 1'b0;
    wr_en = 1'b1; wr_row = 5'd1; wr_col = 5'd1; wr_data = 32'h55;
    start = 1'b1; row_ready = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    chk("frz_idx",  128'(row_index), 128'(1));
    chk("frz_row1", row_data, exp_row(1));
    step();
    step();
    chk("frz_idx3", 128'(row_index), 128'(3));
    step();
    chk("frz_done", 128'(done), 128'(1));
    row_ready = 1'b0;
    step();
    stream_all("restream");

    // Reset mid-stream at row 2: abort, no done, storage cleared.
    start = 1'b1; row_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_idx", 128'(row_index), 128'(2));
    reset = 1'b1;
    step();
    reset = 1'b0; row_ready = 1'b0;
    chk("abort_valid", 128'(row_valid), 128'(0));
    chk("abort_busy",  128'(busy), 128'(0));
    chk("abort_done",  128'(done), 128'(0));
    step();
    chk("abort_nodone", 128'(done), 128'(0));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = '0;
    stream_all("zero");

    // Write coincident with start is committed and visible in row 0.
    wr_en = 1'b1; wr_row = 5'd0; wr_col = 5'd3; wr_data = 32'hA5;
    start = 1'b1; row_ready = 1'b0;
    step();
    wr_en = 1'b0; start = 1'b0;
    m[0][3] = 32'hA5;
    chk("wrstart_lsw", 128'(row_data[31:0]), 128'(32'h0000_00A5));
    chk("wrstart_row", row_data, exp_row(0));
    row_ready = 1'b1;
    for (int r = 0; r < N; r++) step();
    chk("wrstart_done", 128'(done), 128'(1));
    row_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
